// File: rtl/multiop_pkg.sv
// Shared types and sizing helpers for the multi-operand adder family.
package multiop_pkg;

    localparam int DEF_W = 7;
    localparam int DEF_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_ADD,
        OP_CLR
    } acc_op_t;

    // N operands of 2^W-1 need W + clog2(N) bits.
    function automatic int sum_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

endpackage

// File: rtl/operand_acc_dp.sv
// Accumulator register and operand counter for the serial accumulator.
module operand_acc_dp
    import multiop_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int N  = DEF_N,
    parameter int SW = sum_width(W, N),
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  acc_op_t       op,
    input  logic [W-1:0]  data,
    output logic [SW-1:0] acc,
    output logic [CW-1:0] count
);

    logic [SW-1:0] acc_q;
    logic [SW-1:0] acc_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        unique case (op)
            OP_LOAD: begin
                acc_d   = SW'(data);
                count_d = CW'(1);
            end
            OP_ADD: begin
                acc_d   = acc_q + SW'(data);
                count_d = count_q + CW'(1);
            end
            OP_CLR: begin
                acc_d   = '0;
                count_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    assign acc   = acc_q;
    assign count = count_q;

endmodule

// File: rtl/serial_operand_accumulator.sv
// Streams N unsigned operands in over valid/ready and emits their exact sum.
module serial_operand_accumulator
    import multiop_pkg::*;
#(
    parameter  int W  = DEF_W,
    parameter  int N  = DEF_N,
    localparam int SW = sum_width(W, N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum,
    output logic          busy
);

    localparam int CW = $clog2(N);

    state_t        state_q;
    state_t        state_d;
    acc_op_t       op;
    logic [SW-1:0] acc;
    logic [CW-1:0] count;
    logic          last;

    operand_acc_dp #(
        .W  (W),
        .N  (N),
        .SW (SW),
        .CW (CW)
    ) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .op    (op),
        .data  (in_data),
        .acc   (acc),
        .count (count)
    );

    assign last = (count == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        op      = OP_HOLD;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op      = OP_LOAD;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    op = OP_ADD;
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    op      = OP_CLR;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake flags decode registered state only.
    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = acc;

endmodule
